axi_burst_mem_slave: RTL and testbench

AXI_BURST_MEM_SLAVE -- requirements
Module: axi_burst_mem_slave

---
 rtl/axi_burst_mem_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_mem_slave.sv
// AXI burst memory slave: byte-addressed RAM behind independent write and read burst FSMs.
// FIXED/INCR/WRAP bursts; illegal attributes or out-of-range beats answer SLVERR and never touch memory.
module axi_burst_mem_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_BYTES  = 512
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  localparam int BPW  = DATA_WIDTH / 8;
  localparam int LB   = $clog2(BPW);
  localparam int MA_W = $clog2(MEM_BYTES);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic {R_IDLE, R_DATA} rstate_e;

  logic [7:0] mem [MEM_BYTES];

  wstate_e               wstate_q, wstate_d;
  rstate_e               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
  logic [7:0]            wlen_q, wlen_d, rlen_q, rlen_d;
  logic [7:0]            wcnt_q, wcnt_d, rcnt_q, rcnt_d;
  logic [2:0]            wsize_q, wsize_d, rsize_q, rsize_d;
  logic [1:0]            wburst_q, wburst_d, rburst_q, rburst_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, r_word;
  logic                  w_mem_we, w_beat_bad, w_last_cnt, r_fetch, r_bad;

  // A beat is bad if the burst attributes are illegal or the beat itself falls outside memory.
  function automatic logic beat_err(input logic [ADDR_WIDTH-1:0] addr, input logic [2:0] size,
                                    input logic [1:0] burst, input logic [7:0] len);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (size > 3'(LB)) || (burst == 2'b11) || bad_wrap ||
           (addr >= ADDR_WIDTH'(MEM_BYTES));
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [2:0] size,
                                                      input logic [1:0] burst,
                                                      input logic [7:0] len);
    logic [ADDR_WIDTH-1:0] step, incr, wmask;
    step  = ONE << size;
    incr  = (addr & ~(step - ONE)) + step;
    wmask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    case (burst)
      2'b00:   return addr;
      2'b10:   return (addr & ~wmask) | (incr & wmask);
      default: return incr;
    endcase
  endfunction

  always_comb begin
    wstate_d   = wstate_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wcnt_d     = wcnt_q;
    werr_d     = werr_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_mem_we   = 1'b0;
    w_beat_bad = beat_err(waddr_q, wsize_q, wburst_q, wlen_q);
    w_last_cnt = (wcnt_q == wlen_q);
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (awvalid && awready_q) begin
          wstate_d  = W_DATA;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          waddr_d   = awaddr;
          wlen_d    = awlen;
          wsize_d   = awsize;
          wburst_d  = awburst;
          wcnt_d    = 8'd0;
          werr_d    = 1'b0;
        end
      end
      W_DATA: begin
        if (wvalid && wready_q) begin
          w_mem_we = !w_beat_bad;
          // The beat counter alone ends the burst; wlast only contributes to the error flag.
          if (w_last_cnt) begin
            wstate_d = W_RESP;
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (werr_q || w_beat_bad || !wlast) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wcnt_d  = wcnt_q + 8'd1;
            waddr_d = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
            werr_d  = werr_q || w_beat_bad || wlast;
          end
        end
      end
      W_RESP: begin
        if (bready) begin
          wstate_d  = W_IDLE;
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d  = rstate_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    r_fetch   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (arvalid && arready_q) begin
          rstate_d  = R_DATA;
          arready_d = 1'b0;
          rvalid_d  = 1'b1;
          raddr_d   = araddr;
          rlen_d    = arlen;
          rsize_d   = arsize;
          rburst_d  = arburst;
          rcnt_d    = 8'd0;
          rlast_d   = (arlen == 8'd0);
          r_fetch   = 1'b1;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rstate_d  = R_IDLE;
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
          end else begin
            rcnt_d  = rcnt_q + 8'd1;
            raddr_d = next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
            rlast_d = ((rcnt_q + 8'd1) == rlen_q);
            r_fetch = 1'b1;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    // Sampling memory before this edge's write lands gives read-old-value on a collision.
    r_bad  = beat_err(raddr_d, rsize_d, rburst_d, rlen_d);
    r_word = '0;
    for (int i = 0; i < BPW; i++) begin
      r_word[8*i +: 8] = mem[{raddr_d[MA_W-1:LB], LB'(i)}];
    end
    if (r_fetch) begin
      rdata_d = r_bad ? '0 : r_word;
      rresp_d = r_bad ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_q  <= W_IDLE;
      wcnt_q    <= 8'd0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      rcnt_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wcnt_q    <= wcnt_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  // Burst attributes and memory contents are data: they survive reset untouched.
  always_ff @(posedge clk) begin
    waddr_q  <= waddr_d;
    wlen_q   <= wlen_d;
    wsize_q  <= wsize_d;
    wburst_q <= wburst_d;
    raddr_q  <= raddr_d;
    rlen_q   <= rlen_d;
    rsize_q  <= rsize_d;
    rburst_q <= rburst_d;
    if (w_mem_we) begin
      for (int i = 0; i < BPW; i++) begin
        if (wstrb[i]) mem[{waddr_q[MA_W-1:LB], LB'(i)}] <= wdata[8*i +: 8];
      end
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rlast   = rlast_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Bench for axi_burst_mem_slave: directed corner cases plus random bursts checked against a
// byte-array model whose beat addresses come from closed-form AXI address arithmetic.
module tb_axi_burst_mem_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [7:0]    awlen = '0, arlen = '0;
  logic [2:0]    awsize = '0, arsize = '0;
  logic [1:0]    awburst = '0, arburst = '0;
  logic          awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b0;
  logic          arvalid = 1'b0, rready = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid, rlast;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;

  axi_burst_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0]  ref_mem [MB];
  logic [31:0] bd [256];
  logic [3:0]  bs [256];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address of beat k, straight from the burst rules rather than a running register.
  function automatic int unsigned beat_addr(input int unsigned a, input int unsigned len,
                                            input int unsigned size, input int unsigned burst,
                                            input int unsigned k);
    int unsigned step, aligned, bnd, lower;
    step    = 1 << size;
    aligned = a - (a % step);
    bnd     = (len + 1) * step;
    lower   = a - (a % bnd);
    if (k == 0 || burst == 0) return a;
    if (burst == 2) return lower + ((aligned - lower + k * step) % bnd);
    return aligned + k * step;
  endfunction

  function automatic bit attr_err(input int unsigned len, input int unsigned size,
                                  input int unsigned burst);
    return size > 2 || burst == 3 ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [31:0] model_word(input int unsigned a);
    int unsigned b;
    b = a - (a % 4);
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  task automatic aw_start(input int unsigned addr, input int unsigned len,
                          input int unsigned size, input int unsigned burst);
    int t;
    awaddr = AW'(addr); awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin @(posedge clk); #1; t++; end
    check("awready_wait", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input int k, input logic last);
    int t;
    wdata = bd[k]; wstrb = bs[k]; wlast = last; wvalid = 1'b1;
    t = 0;
    while (!wready && t < 50) begin @(posedge clk); #1; t++; end
    if (!wready) check("wready_wait", wready, 1);
    @(posedge clk); #1;
  endtask

  function automatic void model_beat(input int unsigned addr, input int unsigned len,
                                     input int unsigned size, input int unsigned burst,
                                     input int k, inout bit err);
    int unsigned ba;
    ba = beat_addr(addr, len, size, burst, k);
    if (attr_err(len, size, burst) || ba >= MB) err = 1'b1;
    else for (int i = 0; i < 4; i++) if (bs[k][i]) ref_mem[ba - (ba % 4) + i] = bd[k][8*i +: 8];
  endfunction

  task automatic write_burst(input int unsigned addr, input int unsigned len,
                             input int unsigned size, input int unsigned burst,
                             input int flip, input int hold, output logic [1:0] resp);
    bit exp_err;
    logic [1:0] held;
    exp_err = 1'b0;
    aw_start(addr, len, size, burst);
    for (int k = 0; k <= int'(len); k++) begin
      w_beat(k, (k == int'(len)) ^ (k == flip));
      model_beat(addr, len, size, burst, k, exp_err);
      if (k == flip) exp_err = 1'b1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("bvalid_rise", bvalid, 1);
    held = bresp;
    for (int d = 0; d < hold; d++) begin
      @(posedge clk); #1;
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, held);
      check("awready_busy", awready, 0);
    end
    resp = bresp;
    check("bresp", bresp, exp_err ? 2'b10 : 2'b00);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("bvalid_fall", bvalid, 0);
  endtask

  task automatic read_burst(input int unsigned addr, input int unsigned len,
                            input int unsigned size, input int unsigned burst,
                            input bit stall, output logic [31:0] last_data,
                            output logic [1:0] last_resp);
    int t, k;
    int unsigned ba;
    bit err, stalled, hs;
    logic [31:0] prev;
    araddr = AW'(addr); arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1; rready = 1'b0;
    t = 0;
    while (!arready && t < 50) begin @(posedge clk); #1; t++; end
    check("arready_wait", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid_first", rvalid, 1);
    k = 0; t = 0; stalled = 1'b0; prev = '0; last_data = '0; last_resp = '0;
    while (k <= int'(len) && t < 3000) begin
      hs = 1'b0;
      if (rvalid) begin
        ba  = beat_addr(addr, len, size, burst, k);
        err = attr_err(len, size, burst) || ba >= MB;
        if (stalled) begin
          check("rdata_stable", rdata, prev);
        end else begin
          check("rdata", rdata, err ? 32'h0 : model_word(ba));
          check("rresp", rresp, err ? 2'b10 : 2'b00);
          check("rlast", rlast, k == int'(len));
        end
        prev = rdata; last_data = rdata; last_resp = rresp;
        rready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled = !rready;
        hs      = rready;
      end
      @(posedge clk); #1;
      t++;
      if (hs) k++;
    end
    rready = 1'b0;
    check("r_beats", k, len + 1);
    check("rvalid_end", rvalid, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, lr;
    logic [31:0] ld, pre;
    int unsigned a, l, s, b, r;

    repeat (2) @(posedge clk);
    #1;
    check("rst_awready", awready, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_rresp", rresp, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;

    // Fill the whole memory so the model starts from known contents.
    for (int k = 0; k < 128; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    write_burst(0, 127, 2, 1, -1, 0, resp);

    for (int k = 0; k < 4; k++) begin bd[k] = 32'h11111111 * (k + 1); bs[k] = 4'hF; end
    write_burst(32'h10, 3, 2, 1, -1, 0, resp);
    check("incr_bresp", resp, 2'b00);
    read_burst(32'h10, 3, 2, 1, 0, ld, lr);
    check("incr_last_word", ld, 32'h44444444);

    for (int k = 0; k < 4; k++) begin bd[k] = 32'hA0A0A0A0 + k; bs[k] = 4'hF; end
    write_burst(32'h38, 3, 2, 2, -1, 0, resp);
    read_burst(32'h38, 3, 2, 2, 0, ld, lr);
    read_burst(32'h30, 3, 2, 1, 0, ld, lr);
    check("wrap_0x3c", ld, 32'hA0A0A0A1);

    read_burst(32'h20, 0, 2, 1, 0, pre, lr);
    bd[0] = 32'hAABBCCDD; bs[0] = 4'b0001;
    bd[1] = 32'h11223344; bs[1] = 4'b0100;
    write_burst(32'h20, 1, 2, 0, -1, 0, resp);
    read_burst(32'h20, 0, 2, 1, 0, ld, lr);
    check("fixed_b20", ld[7:0], 8'hDD);
    check("fixed_b21", ld[15:8], pre[15:8]);
    check("fixed_b22", ld[23:16], 8'h22);
    check("fixed_b23", ld[31:24], pre[31:24]);

    read_burst(32'h40, 1, 2, 1, 0, pre, lr);
    for (int k = 0; k < 2; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    write_burst(32'h40, 1, 3, 1, -1, 0, resp);
    check("size_err_bresp", resp, 2'b10);
    read_burst(32'h40, 1, 2, 1, 0, ld, lr);
    check("size_err_unchanged", ld, pre);
    read_burst(MB, 0, 2, 1, 0, ld, lr);
    check("oob_rdata", ld, 0);
    check("oob_rresp", lr, 2'b10);

    bd[0] = $urandom; bs[0] = 4'h0; bd[1] = $urandom; bs[1] = 4'h0;
    write_burst(32'h60, 1, 2, 1, 0, 0, resp);
    check("wlast_err_bresp", resp, 2'b10);

    for (int k = 0; k < 2; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    write_burst(32'h50, 1, 2, 1, -1, 5, resp);
    check("bp_bresp", resp, 2'b00);
    read_burst(32'h40, 15, 2, 1, 1, ld, lr);

    // Abandon a write burst at its third beat; the first two beats must persist.
    for (int k = 0; k < 4; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    aw_start(32'h80, 3, 2, 1);
    begin
      bit dummy;
      dummy = 1'b0;
      for (int k = 0; k < 2; k++) begin
        w_beat(k, 1'b0);
        model_beat(32'h80, 3, 2, 1, k, dummy);
      end
    end
    wdata = bd[2]; wstrb = bs[2]; wlast = 1'b0; wvalid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("mid_awready", awready, 0);
    check("mid_wready", wready, 0);
    check("mid_bvalid", bvalid, 0);
    check("mid_bresp", bresp, 0);
    check("mid_arready", arready, 0);
    check("mid_rvalid", rvalid, 0);
    check("mid_rlast", rlast, 0);
    check("mid_rresp", rresp, 0);
    check("mid_rdata", rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; wvalid = 1'b0;
    for (int k = 0; k < 2; k++) begin bd[k] = $urandom; bs[k] = 4'hF; end
    write_burst(32'h90, 1, 2, 1, -1, 0, resp);
    check("post_rst_bresp", resp, 2'b00);
    read_burst(32'h80, 7, 2, 1, 0, ld, lr);

    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      b = (r < 2) ? 0 : (r < 6) ? 1 : (r < 9) ? 2 : 3;
      s = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      if (b == 2) begin
        r = $urandom_range(0, 4);
        l = (r == 4) ? 2 : (2 << r) - 1;
      end else begin
        l = $urandom_range(0, 7);
      end
      a = $urandom_range(0, MB + 47);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k <= int'(l); k++) begin bd[k] = $urandom; bs[k] = 4'($urandom); end
        write_burst(a, l, s, b, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, l)) : -1,
                    int'($urandom_range(0, 2)), resp);
      end else begin
        read_burst(a, l, s, b, 1, ld, lr);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
